// File: rtl/rst_seq_pkg.sv
// Shared state encoding and default timing constants for the reset sequencer.
package rst_seq_pkg;

   typedef enum logic [1:0] {
      S_IDLE,
      S_CLK_ON,
      S_RELEASE,
      S_RUN
   } rst_seq_state_e;

   localparam int N_DOM_DEF    = 4;
   localparam int CNT_W_DEF    = 8;
   localparam int CLK_PRE_DEF  = 4;
   localparam int RST_GAP_DEF  = 8;
   localparam int WDOG_CYC_DEF = 64;

endpackage

// File: rtl/rst_seq_timer.sv
// Loadable down-counter that stops at zero; paces both the clock pre-run and the release gaps.
module rst_seq_timer
   import rst_seq_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst_async,
   input  logic             load,
   input  logic [CNT_W-1:0] val,
   output logic             zero
);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or posedge rst_async) begin
      if (rst_async) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= val;
      end else if (cnt != '0) begin
         cnt <= cnt - 1'b1;
      end
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/rst_seq_ctrl.sv
// Per-domain clock-enable / reset sequencer with sleep handshake and software re-reset.
// Define RST_SEQ_WDOG_EN to build the per-domain sleep watchdog behind wdog_err.
module rst_seq_ctrl
   import rst_seq_pkg::*;
#(
   parameter int N_DOM    = N_DOM_DEF,
   parameter int CNT_W    = CNT_W_DEF,
   parameter int CLK_PRE  = CLK_PRE_DEF,
   parameter int RST_GAP  = RST_GAP_DEF,
   parameter int WDOG_CYC = WDOG_CYC_DEF
) (
   input  logic             clk,
   input  logic             rst_async,
   input  logic [N_DOM-1:0] dom_en_i,
   input  logic             sw_rst_req,
   input  logic [N_DOM-1:0] sleep_req,
   input  logic [N_DOM-1:0] dom_idle,
   output logic [N_DOM-1:0] cg_en,
   output logic [N_DOM-1:0] dom_rst,
   output logic [N_DOM-1:0] sleep_ack,
   output logic             seq_done,
   output logic             wdog_err
);

   localparam int IDX_W = (N_DOM > 1) ? $clog2(N_DOM) : 1;

   rst_seq_state_e   state;
   logic [N_DOM-1:0] mask;
   logic [IDX_W-1:0] ptr;
   logic             tmr_load;
   logic [CNT_W-1:0] tmr_val;
   logic             tmr_zero;
   logic [IDX_W:0]   first_res;
   logic [IDX_W:0]   after_first_res;
   logic [IDX_W:0]   after_ptr_res;

   // Lowest enabled domain at or above 'start'; MSB of the result flags a hit.
   function automatic logic [IDX_W:0] find_from(input logic [N_DOM-1:0] m, input int start);
      logic [IDX_W:0] res;
      res = '0;
      for (int i = N_DOM - 1; i >= 0; i--) begin
         if (m[i] && i >= start) res = {1'b1, IDX_W'(i)};
      end
      return res;
   endfunction

   always_comb begin
      first_res       = find_from(mask, 0);
      after_first_res = find_from(mask, int'(first_res[IDX_W-1:0]) + 1);
      after_ptr_res   = find_from(mask, int'(ptr) + 1);
   end

   // The pre-run count is loaded on the IDLE edge; each expiry reloads the gap.
   always_comb begin
      tmr_load = 1'b0;
      tmr_val  = CNT_W'(CLK_PRE - 1);
      case (state)
         S_IDLE: tmr_load = 1'b1;
         S_CLK_ON, S_RELEASE: begin
            if (tmr_zero) begin
               tmr_load = 1'b1;
               tmr_val  = CNT_W'(RST_GAP - 1);
            end
         end
         default: ;
      endcase
   end

   rst_seq_timer #(.CNT_W(CNT_W)) u_timer (
      .clk       (clk),
      .rst_async (rst_async),
      .load      (tmr_load),
      .val       (tmr_val),
      .zero      (tmr_zero)
   );

   always_ff @(posedge clk or posedge rst_async) begin
      if (rst_async) begin
         state     <= S_IDLE;
         mask      <= '0;
         ptr       <= '0;
         cg_en     <= '0;
         dom_rst   <= '1;
         sleep_ack <= '0;
         seq_done  <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               mask    <= dom_en_i;
               cg_en   <= dom_en_i;
               dom_rst <= '1;
               state   <= S_CLK_ON;
            end
            S_CLK_ON: begin
               if (tmr_zero) begin
                  if (first_res[IDX_W]) begin
                     dom_rst[first_res[IDX_W-1:0]] <= 1'b0;
                  end
                  if (first_res[IDX_W] && after_first_res[IDX_W]) begin
                     ptr   <= after_first_res[IDX_W-1:0];
                     state <= S_RELEASE;
                  end else begin
                     seq_done <= 1'b1;
                     state    <= S_RUN;
                  end
               end
            end
            S_RELEASE: begin
               if (tmr_zero) begin
                  dom_rst[ptr] <= 1'b0;
                  if (after_ptr_res[IDX_W]) begin
                     ptr <= after_ptr_res[IDX_W-1:0];
                  end else begin
                     seq_done <= 1'b1;
                     state    <= S_RUN;
                  end
               end
            end
            S_RUN: begin
               if (sw_rst_req) begin
                  dom_rst   <= '1;
                  sleep_ack <= '0;
                  seq_done  <= 1'b0;
                  cg_en     <= mask;
                  state     <= S_IDLE;
               end else begin
                  // Gate and ack together; on wake the clock returns before the ack drops.
                  for (int i = 0; i < N_DOM; i++) begin
                     if (mask[i]) begin
                        if (!sleep_ack[i]) begin
                           if (sleep_req[i] && dom_idle[i]) begin
                              cg_en[i]     <= 1'b0;
                              sleep_ack[i] <= 1'b1;
                           end
                        end else if (!cg_en[i]) begin
                           if (!sleep_req[i]) cg_en[i] <= 1'b1;
                        end else begin
                           sleep_ack[i] <= 1'b0;
                        end
                     end
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

`ifdef RST_SEQ_WDOG_EN
   logic [CNT_W-1:0] wdog_cnt [N_DOM];

   // A pending sleep request whose domain never goes idle trips the sticky flag.
   always_ff @(posedge clk or posedge rst_async) begin
      if (rst_async) begin
         for (int i = 0; i < N_DOM; i++) wdog_cnt[i] <= '0;
         wdog_err <= 1'b0;
      end else begin
         for (int i = 0; i < N_DOM; i++) begin
            if (state == S_RUN && mask[i] && sleep_req[i] && !sleep_ack[i] && !dom_idle[i]) begin
               if (wdog_cnt[i] == CNT_W'(WDOG_CYC - 1)) begin
                  wdog_err <= 1'b1;
               end else begin
                  wdog_cnt[i] <= wdog_cnt[i] + 1'b1;
               end
            end else if (state != S_RUN || !sleep_req[i] || sleep_ack[i]) begin
               wdog_cnt[i] <= '0;
            end
         end
      end
   end
`else
   // Constant zero; the expression keeps WDOG_CYC referenced in this build.
   assign wdog_err = (WDOG_CYC < 0);
`endif

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Scoreboard bench for rst_seq_ctrl: directed stimulus queues per-edge expectations, a monitor checks them.
module tb_rst_seq_ctrl;

`ifdef RST_SEQ_WDOG_EN
   localparam logic WDOG = 1'b1;
`else
   localparam logic WDOG = 1'b0;
`endif

   logic       clk;
   logic       rst_async;
   logic [3:0] dom_en_i;
   logic       sw_rst_req;
   logic [3:0] sleep_req;
   logic [3:0] dom_idle;
   logic [3:0] cg_en;
   logic [3:0] dom_rst;
   logic [3:0] sleep_ack;
   logic       seq_done;
   logic       wdog_err;

   typedef struct {
      int         cyc;
      int         testId;
      int         edgeNum;
      logic [3:0] cg;
      logic [3:0] rst;
      logic [3:0] ack;
      logic       done;
      logic       werr;
   } expT;

   expT sb[$];
   expT monEntry;
   int  cyc = 0;
   int  base = 0;
   int  testNum = 0;
   int  applied = 0;
   int  miscompares = 0;

   rst_seq_ctrl #(
      .N_DOM    (4),
      .CNT_W    (8),
      .CLK_PRE  (4),
      .RST_GAP  (8),
      .WDOG_CYC (64)
   ) dut (
      .clk        (clk),
      .rst_async  (rst_async),
      .dom_en_i   (dom_en_i),
      .sw_rst_req (sw_rst_req),
      .sleep_req  (sleep_req),
      .dom_idle   (dom_idle),
      .cg_en      (cg_en),
      .dom_rst    (dom_rst),
      .sleep_ack  (sleep_ack),
      .seq_done   (seq_done),
      .wdog_err   (wdog_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Expectation for the outputs seen after edge k of the current sequence.
   task automatic pushExp(input int k, input logic [3:0] cg, input logic [3:0] rst,
                          input logic [3:0] ack, input logic done, input logic werr);
      expT e;
      e.cyc = base + k;
      e.testId = testNum;
      e.edgeNum = k;
      e.cg = cg;
      e.rst = rst;
      e.ack = ack;
      e.done = done;
      e.werr = werr;
      sb.push_back(e);
   endtask

   task automatic waitNeg(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic applyStimulus(input logic [3:0] en, input logic [3:0] req, input logic [3:0] idle);
      dom_en_i = en;
      sleep_req = req;
      dom_idle = idle;
   endtask

   task automatic checkOutput(input expT e);
      applied++;
      if (e.cyc != cyc) begin
         miscompares++;
         $display("[TB] FAIL t%0d_e%0d not sampled: expected at cyc %0d, seen at cyc %0d",
                  e.testId, e.edgeNum, e.cyc, cyc);
      end else if ({cg_en, dom_rst, sleep_ack, seq_done, wdog_err} !==
                   {e.cg, e.rst, e.ack, e.done, e.werr}) begin
         miscompares++;
         $display("[TB] FAIL t%0d_e%0d got cg=%b rst=%b ack=%b done=%b werr=%b want cg=%b rst=%b ack=%b done=%b werr=%b",
                  e.testId, e.edgeNum, cg_en, dom_rst, sleep_ack, seq_done, wdog_err,
                  e.cg, e.rst, e.ack, e.done, e.werr);
      end
   endtask

   // Monitor: outputs are presented once per edge and sampled on the falling edge.
   always @(negedge clk) begin
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
         monEntry = sb.pop_front();
         checkOutput(monEntry);
      end
   end

   initial begin
      #100000;
      $display("[TB] FAIL timeout at cyc %0d", cyc);
      $fatal(1, "[TB] simulation time limit reached");
   end

   initial begin
      rst_async = 1'b1;
      sw_rst_req = 1'b0;
      applyStimulus(4'b1011, 4'b0000, 4'b0000);

      // Reset values while rst_async is held
      waitNeg(1);
      testNum = 0; base = cyc;
      pushExp(1, 4'b0000, 4'b1111, 4'b0000, 1'b0, 1'b0);
      pushExp(2, 4'b0000, 4'b1111, 4'b0000, 1'b0, 1'b0);
      waitNeg(2);

      // Test 1: mask 1011, mask changes and early sleep requests are ignored
      testNum = 1; base = cyc; rst_async = 1'b0;
      pushExp(1,  4'b1011, 4'b1111, 4'b0000, 1'b0, 1'b0);
      pushExp(4,  4'b1011, 4'b1111, 4'b0000, 1'b0, 1'b0);
      pushExp(5,  4'b1011, 4'b1110, 4'b0000, 1'b0, 1'b0);
      pushExp(12, 4'b1011, 4'b1110, 4'b0000, 1'b0, 1'b0);
      pushExp(13, 4'b1011, 4'b1100, 4'b0000, 1'b0, 1'b0);
      pushExp(20, 4'b1011, 4'b1100, 4'b0000, 1'b0, 1'b0);
      pushExp(21, 4'b1011, 4'b0100, 4'b0000, 1'b1, 1'b0);
      pushExp(22, 4'b1011, 4'b0100, 4'b0000, 1'b1, 1'b0);
      waitNeg(2);
      applyStimulus(4'b0000, 4'b0001, 4'b0001);
      waitNeg(8);
      applyStimulus(4'b0000, 4'b0000, 4'b0000);
      waitNeg(12);

      // Test 3: sleep handshake on domain 1; masked domain 2 never acks
      testNum = 3; base = cyc;
      applyStimulus(4'b0000, 4'b0110, 4'b0100);
      pushExp(1,  4'b1011, 4'b0100, 4'b0000, 1'b1, 1'b0);
      pushExp(10, 4'b1011, 4'b0100, 4'b0000, 1'b1, 1'b0);
      pushExp(11, 4'b1001, 4'b0100, 4'b0010, 1'b1, 1'b0);
      pushExp(12, 4'b1011, 4'b0100, 4'b0010, 1'b1, 1'b0);
      pushExp(13, 4'b1011, 4'b0100, 4'b0000, 1'b1, 1'b0);
      waitNeg(10);
      applyStimulus(4'b0000, 4'b0110, 4'b0110);
      waitNeg(1);
      applyStimulus(4'b0000, 4'b0000, 4'b0000);
      waitNeg(2);

      // Test 4: software re-reset, repeats the mask-1011 timeline one edge later
      testNum = 4; base = cyc;
      applyStimulus(4'b1011, 4'b0000, 4'b0000);
      sw_rst_req = 1'b1;
      pushExp(1,  4'b1011, 4'b1111, 4'b0000, 1'b0, 1'b0);
      pushExp(2,  4'b1011, 4'b1111, 4'b0000, 1'b0, 1'b0);
      pushExp(5,  4'b1011, 4'b1111, 4'b0000, 1'b0, 1'b0);
      pushExp(6,  4'b1011, 4'b1110, 4'b0000, 1'b0, 1'b0);
      pushExp(13, 4'b1011, 4'b1110, 4'b0000, 1'b0, 1'b0);
      pushExp(14, 4'b1011, 4'b1100, 4'b0000, 1'b0, 1'b0);
      pushExp(21, 4'b1011, 4'b1100, 4'b0000, 1'b0, 1'b0);
      pushExp(22, 4'b1011, 4'b0100, 4'b0000, 1'b1, 1'b0);
      waitNeg(1);
      sw_rst_req = 1'b0;
      waitNeg(7);
      sw_rst_req = 1'b1;
      waitNeg(1);
      sw_rst_req = 1'b0;
      waitNeg(14);

      // Test 7: re-reset re-samples a new mask (0110)
      testNum = 7; base = cyc;
      applyStimulus(4'b0110, 4'b0000, 4'b0000);
      sw_rst_req = 1'b1;
      pushExp(1,  4'b1011, 4'b1111, 4'b0000, 1'b0, 1'b0);
      pushExp(2,  4'b0110, 4'b1111, 4'b0000, 1'b0, 1'b0);
      pushExp(6,  4'b0110, 4'b1101, 4'b0000, 1'b0, 1'b0);
      pushExp(13, 4'b0110, 4'b1101, 4'b0000, 1'b0, 1'b0);
      pushExp(14, 4'b0110, 4'b1001, 4'b0000, 1'b1, 1'b0);
      waitNeg(1);
      sw_rst_req = 1'b0;
      waitNeg(14);

      // Test 6: domain 2 never idle while requesting sleep
      testNum = 6; base = cyc;
      applyStimulus(4'b0110, 4'b0100, 4'b0000);
      pushExp(1,  4'b0110, 4'b1001, 4'b0000, 1'b1, 1'b0);
      pushExp(63, 4'b0110, 4'b1001, 4'b0000, 1'b1, 1'b0);
      pushExp(64, 4'b0110, 4'b1001, 4'b0000, 1'b1, WDOG);
      pushExp(66, 4'b0110, 4'b1001, 4'b0000, 1'b1, WDOG);
      waitNeg(64);
      applyStimulus(4'b0110, 4'b0000, 4'b0000);
      waitNeg(2);

      // Test 5: asynchronous reset mid-release, then a clean restart
      testNum = 5; base = cyc; rst_async = 1'b1;
      pushExp(1, 4'b0000, 4'b1111, 4'b0000, 1'b0, 1'b0);
      pushExp(2, 4'b0000, 4'b1111, 4'b0000, 1'b0, 1'b0);
      waitNeg(2);
      base = cyc; rst_async = 1'b0;
      applyStimulus(4'b1011, 4'b0000, 4'b0000);
      pushExp(1, 4'b1011, 4'b1111, 4'b0000, 1'b0, 1'b0);
      pushExp(7, 4'b1011, 4'b1110, 4'b0000, 1'b0, 1'b0);
      pushExp(8, 4'b0000, 4'b1111, 4'b0000, 1'b0, 1'b0);
      waitNeg(7);
      @(posedge clk);
      #2 rst_async = 1'b1;
      waitNeg(2);
      base = cyc; rst_async = 1'b0;
      pushExp(1,  4'b1011, 4'b1111, 4'b0000, 1'b0, 1'b0);
      pushExp(5,  4'b1011, 4'b1110, 4'b0000, 1'b0, 1'b0);
      pushExp(13, 4'b1011, 4'b1100, 4'b0000, 1'b0, 1'b0);
      pushExp(21, 4'b1011, 4'b0100, 4'b0000, 1'b1, 1'b0);
      waitNeg(22);

      // Test 2: empty mask finishes at pre-run expiry with nothing released
      testNum = 2; rst_async = 1'b1;
      waitNeg(2);
      base = cyc; rst_async = 1'b0;
      applyStimulus(4'b0000, 4'b0000, 4'b0000);
      pushExp(1, 4'b0000, 4'b1111, 4'b0000, 1'b0, 1'b0);
      pushExp(4, 4'b0000, 4'b1111, 4'b0000, 1'b0, 1'b0);
      pushExp(5, 4'b0000, 4'b1111, 4'b0000, 1'b1, 1'b0);
      pushExp(8, 4'b0000, 4'b1111, 4'b0000, 1'b1, 1'b0);
      waitNeg(9);

      waitNeg(2);
      while (sb.size() > 0) begin
         monEntry = sb.pop_front();
         applied++;
         miscompares++;
         $display("[TB] FAIL t%0d_e%0d never checked (expected at cyc %0d)",
                  monEntry.testId, monEntry.edgeNum, monEntry.cyc);
      end
      $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
      $finish;
   end

endmodule
